// File: rtl/axi_lite_ptgen_master_if.sv
// AXI4-Lite bus bundle for the pattern-generator master.
// The master modport drives the request side; the slave modport answers it.
interface axi_lite_ptgen_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   M_AXI_AWADDR;
  logic [2:0]          M_AXI_AWPROT;
  logic                M_AXI_AWVALID;
  logic                M_AXI_AWREADY;
  logic [DATA_W-1:0]   M_AXI_WDATA;
  logic [DATA_W/8-1:0] M_AXI_WSTRB;
  logic                M_AXI_WVALID;
  logic                M_AXI_WREADY;
  logic [1:0]          M_AXI_BRESP;
  logic                M_AXI_BVALID;
  logic                M_AXI_BREADY;
  logic [ADDR_W-1:0]   M_AXI_ARADDR;
  logic [2:0]          M_AXI_ARPROT;
  logic                M_AXI_ARVALID;
  logic                M_AXI_ARREADY;
  logic [DATA_W-1:0]   M_AXI_RDATA;
  logic [1:0]          M_AXI_RRESP;
  logic                M_AXI_RVALID;
  logic                M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/axi_lite_ptgen_master.sv
// AXI4-Lite pattern generator and self-checker: writes N words SEED+i, reads them
// back and counts mismatches / error responses. One transfer outstanding at a time.
// Optional watchdog: define PTGEN_TIMEOUT_EN to abort a pass stuck for 1023 cycles.
module axi_lite_ptgen_master #(
  parameter logic [63:0] C_M_TARGET_BASE_ADDR = 64'h4000_0000,
  parameter int unsigned C_M_AXI_ADDR_WIDTH   = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH   = 32,
  parameter int unsigned C_M_TRANSACTIONS_NUM = 4,
  parameter logic [63:0] C_PATTERN_SEED       = 64'd1
) (
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic       INIT_AXI_TXN,
  input  logic [1:0] MODE,
  output logic       TXN_DONE,
  output logic       ERROR,
  output logic [7:0] ERR_COUNT,
  axi_lite_ptgen_master_if.master m_axi
);

  localparam int unsigned AddrW     = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DataW     = C_M_AXI_DATA_WIDTH;
  localparam int unsigned IdxW      = $clog2(C_M_TRANSACTIONS_NUM) + 1;
  localparam int unsigned ByteShift = $clog2(DataW / 8);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(C_M_TRANSACTIONS_NUM - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

  state_e          r_state, w_state_d;
  logic            r_init_q;
  logic [1:0]      r_mode, w_mode_d;
  logic [IdxW-1:0] r_idx, w_idx_d;
  logic            r_launch, w_launch_d;
  logic            r_awvalid, w_awvalid_d;
  logic            r_wvalid, w_wvalid_d;
  logic            r_bready, w_bready_d;
  logic            r_arvalid, w_arvalid_d;
  logic            r_rready, w_rready_d;
  logic            r_txn_done, w_txn_done_d;
  logic            r_error, w_error_d;
  logic [7:0]      r_err_count, w_err_count_d;
`ifdef PTGEN_TIMEOUT_EN
  logic [9:0]      r_wdog, w_wdog_d;
`endif

  logic             w_start, w_last;
  logic             w_hs_aw, w_hs_w, w_hs_b, w_hs_ar, w_hs_r;
  logic [AddrW-1:0] w_addr;
  logic [DataW-1:0] w_pattern;
  logic [7:0]       w_cnt_inc;
  logic             w_unused;

  assign w_start   = INIT_AXI_TXN & ~r_init_q;
  assign w_last    = (r_idx == LastIdx);
  assign w_hs_aw   = r_awvalid & m_axi.M_AXI_AWREADY;
  assign w_hs_w    = r_wvalid & m_axi.M_AXI_WREADY;
  assign w_hs_b    = r_bready & m_axi.M_AXI_BVALID;
  assign w_hs_ar   = r_arvalid & m_axi.M_AXI_ARREADY;
  assign w_hs_r    = r_rready & m_axi.M_AXI_RVALID;
  // Payloads derive from the index, which only moves while every VALID is low.
  assign w_addr    = AddrW'(C_M_TARGET_BASE_ADDR) + (AddrW'(r_idx) << ByteShift);
  assign w_pattern = DataW'(C_PATTERN_SEED) + DataW'(r_idx);
  assign w_cnt_inc = (r_err_count == 8'hFF) ? 8'hFF : r_err_count + 8'd1;
  assign w_unused  = ^{m_axi.M_AXI_BRESP[0], m_axi.M_AXI_RRESP[0]};

  // Next-state and channel control for the pass sequencer.
  always_comb begin
    w_state_d     = r_state;
    w_mode_d      = r_mode;
    w_idx_d       = r_idx;
    w_launch_d    = r_launch;
    w_awvalid_d   = r_awvalid;
    w_wvalid_d    = r_wvalid;
    w_bready_d    = r_bready;
    w_arvalid_d   = r_arvalid;
    w_rready_d    = r_rready;
    w_txn_done_d  = r_txn_done;
    w_error_d     = r_error;
    w_err_count_d = r_err_count;
`ifdef PTGEN_TIMEOUT_EN
    w_wdog_d      = r_wdog;
`endif
    unique case (r_state)
      StIdle, StDone: begin
        if (w_start) begin
          w_txn_done_d  = 1'b0;
          w_error_d     = 1'b0;
          w_err_count_d = 8'd0;
          w_idx_d       = '0;
          w_mode_d      = MODE;
          if (MODE == 2'b11) begin
            w_state_d    = StDone;
            w_error_d    = 1'b1;
            w_txn_done_d = 1'b1;
          end else if (MODE == 2'b10) begin
            w_state_d  = StRead;
            w_launch_d = 1'b1;
          end else begin
            w_state_d  = StWrite;
            w_launch_d = 1'b1;
          end
        end
      end
      StWrite: begin
        if (r_launch) begin
          w_launch_d  = 1'b0;
          w_awvalid_d = 1'b1;
          w_wvalid_d  = 1'b1;
        end
        if (w_hs_aw) w_awvalid_d = 1'b0;
        if (w_hs_w)  w_wvalid_d  = 1'b0;
        // Wait for B only once both address and data have been accepted.
        if ((r_awvalid | r_wvalid) && !(w_awvalid_d | w_wvalid_d)) w_bready_d = 1'b1;
        if (w_hs_b) begin
          w_bready_d = 1'b0;
          if (m_axi.M_AXI_BRESP[1]) begin
            w_error_d     = 1'b1;
            w_err_count_d = w_cnt_inc;
          end
          if (w_last) begin
            w_idx_d = '0;
            if (r_mode == 2'b00) begin
              w_state_d  = StRead;
              w_launch_d = 1'b1;
            end else begin
              w_state_d    = StDone;
              w_txn_done_d = 1'b1;
            end
          end else begin
            w_idx_d    = r_idx + 1'b1;
            w_launch_d = 1'b1;
          end
        end
      end
      StRead: begin
        if (r_launch) begin
          w_launch_d  = 1'b0;
          w_arvalid_d = 1'b1;
        end
        if (w_hs_ar) begin
          w_arvalid_d = 1'b0;
          w_rready_d  = 1'b1;
        end
        if (w_hs_r) begin
          w_rready_d = 1'b0;
          if (m_axi.M_AXI_RRESP[1] || (m_axi.M_AXI_RDATA != w_pattern)) begin
            w_error_d     = 1'b1;
            w_err_count_d = w_cnt_inc;
          end
          if (w_last) begin
            w_state_d    = StDone;
            w_txn_done_d = 1'b1;
          end else begin
            w_idx_d    = r_idx + 1'b1;
            w_launch_d = 1'b1;
          end
        end
      end
    endcase
`ifdef PTGEN_TIMEOUT_EN
    if (!(r_awvalid | r_wvalid | r_bready | r_arvalid | r_rready) ||
        (w_hs_aw | w_hs_w | w_hs_b | w_hs_ar | w_hs_r)) begin
      w_wdog_d = 10'd0;
    end else begin
      w_wdog_d = r_wdog + 10'd1;
    end
    // Stuck slave: abandon the pass and report it as fully failed.
    if (r_wdog == 10'h3FF) begin
      w_wdog_d      = 10'd0;
      w_launch_d    = 1'b0;
      w_awvalid_d   = 1'b0;
      w_wvalid_d    = 1'b0;
      w_bready_d    = 1'b0;
      w_arvalid_d   = 1'b0;
      w_rready_d    = 1'b0;
      w_error_d     = 1'b1;
      w_err_count_d = 8'hFF;
      w_state_d     = StDone;
      w_txn_done_d  = 1'b1;
    end
`endif
  end

  // State registers with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state     <= StIdle;
      r_init_q    <= 1'b0;
      r_mode      <= 2'b00;
      r_idx       <= '0;
      r_launch    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_txn_done  <= 1'b0;
      r_error     <= 1'b0;
      r_err_count <= 8'd0;
`ifdef PTGEN_TIMEOUT_EN
      r_wdog      <= 10'd0;
`endif
    end else begin
      r_state     <= w_state_d;
      r_init_q    <= INIT_AXI_TXN;
      r_mode      <= w_mode_d;
      r_idx       <= w_idx_d;
      r_launch    <= w_launch_d;
      r_awvalid   <= w_awvalid_d;
      r_wvalid    <= w_wvalid_d;
      r_bready    <= w_bready_d;
      r_arvalid   <= w_arvalid_d;
      r_rready    <= w_rready_d;
      r_txn_done  <= w_txn_done_d;
      r_error     <= w_error_d;
      r_err_count <= w_err_count_d;
`ifdef PTGEN_TIMEOUT_EN
      r_wdog      <= w_wdog_d;
`endif
    end
  end

  assign TXN_DONE  = r_txn_done;
  assign ERROR     = r_error;
  assign ERR_COUNT = r_err_count;

  assign m_axi.M_AXI_AWADDR  = w_addr;
  assign m_axi.M_AXI_AWPROT  = 3'b000;
  assign m_axi.M_AXI_AWVALID = r_awvalid;
  assign m_axi.M_AXI_WDATA   = w_pattern;
  assign m_axi.M_AXI_WSTRB   = '1;
  assign m_axi.M_AXI_WVALID  = r_wvalid;
  assign m_axi.M_AXI_BREADY  = r_bready;
  assign m_axi.M_AXI_ARADDR  = w_addr;
  assign m_axi.M_AXI_ARPROT  = 3'b000;
  assign m_axi.M_AXI_ARVALID = r_arvalid;
  assign m_axi.M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axi_lite_ptgen_master.sv
// Directed + randomized bench for axi_lite_ptgen_master with a memory-backed slave.
module tb_axi_lite_ptgen_master;
  localparam int unsigned N    = 4;
  localparam logic [31:0] Base = 32'h4000_0000;
  localparam logic [31:0] Seed = 32'd1;

  logic       ACLK = 1'b0;
  logic       ARESET = 1'b1;
  logic       INIT_AXI_TXN = 1'b0;
  logic [1:0] MODE = 2'b00;
  logic       TXN_DONE, ERROR;
  logic [7:0] ERR_COUNT;

  always #5 ACLK = ~ACLK;

  axi_lite_ptgen_master_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  axi_lite_ptgen_master #(
    .C_M_TARGET_BASE_ADDR(64'h4000_0000),
    .C_M_AXI_ADDR_WIDTH  (32),
    .C_M_AXI_DATA_WIDTH  (32),
    .C_M_TRANSACTIONS_NUM(N),
    .C_PATTERN_SEED      (64'd1)
  ) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .INIT_AXI_TXN(INIT_AXI_TXN),
    .MODE        (MODE),
    .TXN_DONE    (TXN_DONE),
    .ERROR       (ERROR),
    .ERR_COUNT   (ERR_COUNT),
    .m_axi       (axi)
  );

  // Slave configuration, written only by the stimulus block.
  logic        rnd_en = 1'b0;
  logic        no_b = 1'b0;
  int          slverr_at = -1;
  logic [31:0] corrupt_addr = 32'h0;
  logic [31:0] rd_xor = 32'h0;

  // Slave state and logs, written only by the slave/monitor blocks.
  logic        sl_awready = 1'b0, sl_wready = 1'b0, sl_arready = 1'b0;
  logic        sl_bvalid = 1'b0, sl_rvalid = 1'b0;
  logic [1:0]  sl_bresp = 2'b00;
  logic [31:0] sl_rdata = 32'h0;
  logic        aw_got = 1'b0, w_got = 1'b0;
  logic [31:0] aw_lat, w_lat;
  logic [31:0] mem [0:255];
  logic [31:0] wr_addr [0:1023];
  logic [31:0] wr_data [0:1023];
  int          wr_n = 0, rd_n = 0;
  int          viol = 0, valid_seen = 0, done_falls = 0;
  logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0, p_done = 0;
  logic [31:0] p_awa = 0, p_wd = 0, p_ara = 0;

  assign axi.M_AXI_AWREADY = sl_awready;
  assign axi.M_AXI_WREADY  = sl_wready;
  assign axi.M_AXI_ARREADY = sl_arready;
  assign axi.M_AXI_BVALID  = sl_bvalid;
  assign axi.M_AXI_BRESP   = sl_bresp;
  assign axi.M_AXI_RVALID  = sl_rvalid;
  assign axi.M_AXI_RDATA   = sl_rdata;
  assign axi.M_AXI_RRESP   = 2'b00;

  logic        hs_aw, hs_w, aw_now, w_now;
  logic [31:0] addr_now, data_now;
  assign hs_aw    = axi.M_AXI_AWVALID & sl_awready;
  assign hs_w     = axi.M_AXI_WVALID & sl_wready;
  assign aw_now   = aw_got | hs_aw;
  assign w_now    = w_got | hs_w;
  assign addr_now = hs_aw ? axi.M_AXI_AWADDR : aw_lat;
  assign data_now = hs_w ? axi.M_AXI_WDATA : w_lat;

  // Memory slave: B answers in the same edge both AW and W complete.
  always @(posedge ACLK) begin
    if (ARESET) begin
      sl_awready <= 1'b0; sl_wready <= 1'b0; sl_arready <= 1'b0;
      sl_bvalid <= 1'b0; sl_rvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
    end else begin
      sl_awready <= rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
      sl_wready  <= rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
      sl_arready <= rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hs_aw) begin aw_got <= 1'b1; aw_lat <= axi.M_AXI_AWADDR; end
      if (hs_w)  begin w_got <= 1'b1;  w_lat <= axi.M_AXI_WDATA; end
      if (aw_now && w_now && !sl_bvalid) begin
        mem[addr_now[9:2]]  <= data_now;
        wr_addr[wr_n % 1024] <= addr_now;
        wr_data[wr_n % 1024] <= data_now;
        wr_n      <= wr_n + 1;
        sl_bvalid <= !no_b;
        sl_bresp  <= (wr_n == slverr_at) ? 2'b10 : 2'b00;
        aw_got    <= 1'b0;
        w_got     <= 1'b0;
      end
      if (sl_bvalid && axi.M_AXI_BREADY) sl_bvalid <= 1'b0;
      if (axi.M_AXI_ARVALID && sl_arready) begin
        sl_rvalid <= 1'b1;
        sl_rdata  <= (axi.M_AXI_ARADDR == corrupt_addr) ? 32'hDEAD
                   : (mem[axi.M_AXI_ARADDR[9:2]] ^ rd_xor);
        rd_n      <= rd_n + 1;
      end
      if (sl_rvalid && axi.M_AXI_RREADY) sl_rvalid <= 1'b0;
    end
  end

  // Protocol monitor: VALID held and payload stable until handshake.
  always @(posedge ACLK) begin
    if (ARESET) begin
      p_awv <= 1'b0; p_wv <= 1'b0; p_arv <= 1'b0; p_done <= 1'b0;
    end else begin
      if (p_awv && !p_awr && (!axi.M_AXI_AWVALID || axi.M_AXI_AWADDR != p_awa)) viol <= viol + 1;
      if (p_wv && !p_wr && (!axi.M_AXI_WVALID || axi.M_AXI_WDATA != p_wd)) viol <= viol + 1;
      if (p_arv && !p_arr && (!axi.M_AXI_ARVALID || axi.M_AXI_ARADDR != p_ara)) viol <= viol + 1;
      if (axi.M_AXI_AWVALID || axi.M_AXI_WVALID || axi.M_AXI_ARVALID) valid_seen <= valid_seen + 1;
      if (p_done && !TXN_DONE) done_falls <= done_falls + 1;
      p_awv <= axi.M_AXI_AWVALID; p_awr <= sl_awready; p_awa <= axi.M_AXI_AWADDR;
      p_wv  <= axi.M_AXI_WVALID;  p_wr  <= sl_wready;  p_wd  <= axi.M_AXI_WDATA;
      p_arv <= axi.M_AXI_ARVALID; p_arr <= sl_arready; p_ara <= axi.M_AXI_ARADDR;
      p_done <= TXN_DONE;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_pass(input logic [1:0] m);
    MODE = m;
    INIT_AXI_TXN = 1'b1;
    tick(1);
    INIT_AXI_TXN = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cyc);
    cyc = 0;
    while (!TXN_DONE && cyc < budget) begin
      tick(1);
      cyc++;
    end
    check({tag, "_done"}, TXN_DONE, 1);
  endtask

  // Reference: the pass must write SEED+i to BASE+4*i for i = 0..N-1, in order.
  task automatic check_writes(input string tag, input int base_n);
    check({tag, "_nwr"}, wr_n - base_n, N);
    for (int i = 0; i < N; i++) begin
      check({tag, "_addr"}, wr_addr[(base_n + i) % 1024], Base + 32'(4 * i));
      check({tag, "_data"}, wr_data[(base_n + i) % 1024], Seed + 32'(i));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int cyc, b_wr, b_rd, b_v, b_f, s, c, exp_err;

    // Reset state.
    ARESET = 1'b1;
    tick(3);
    ARESET = 1'b0;
    tick(1);
    check("rst_done", TXN_DONE, 0);
    check("rst_error", ERROR, 0);
    check("rst_cnt", ERR_COUNT, 0);
    check("rst_valids", {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_ARVALID}, 0);
    check("rst_readies", {axi.M_AXI_BREADY, axi.M_AXI_RREADY}, 0);

    // 1: clean write+read+compare with zero-wait slave.
    b_wr = wr_n; b_rd = rd_n;
    start_pass(2'b00);
    wait_done("t1", 40, cyc);
    check("t1_latency_le30", cyc <= 30, 1);
    check("t1_error", ERROR, 0);
    check("t1_cnt", ERR_COUNT, 0);
    check("t1_nrd", rd_n - b_rd, N);
    check_writes("t1", b_wr);
    check("t1_prot", {axi.M_AXI_AWPROT, axi.M_AXI_ARPROT, axi.M_AXI_WSTRB}, 10'h00F);

    // 2: word at BASE+8 read back as 0xDEAD.
    corrupt_addr = Base + 32'h8;
    start_pass(2'b00);
    wait_done("t2", 40, cyc);
    check("t2_error", ERROR, 1);
    check("t2_cnt", ERR_COUNT, 1);
    corrupt_addr = 32'h0;

    // 3: random AW/W/AR skew plus SLVERR on write 1.
    rnd_en = 1'b1;
    b_wr = wr_n;
    slverr_at = wr_n + 1;
    start_pass(2'b00);
    wait_done("t3", 600, cyc);
    slverr_at = -1;
    check("t3_error", ERROR, 1);
    check("t3_cnt", ERR_COUNT, 1);
    check_writes("t3", b_wr);

    // Randomized faults: expected count = one per SLVERR write + one per bad read beat.
    for (int k = 0; k < 4; k++) begin
      s = $urandom_range(0, N);
      c = $urandom_range(0, N);
      exp_err = ((s < N) ? 1 : 0) + ((c < N) ? 1 : 0);
      slverr_at = (s < N) ? wr_n + s : -1;
      corrupt_addr = (c < N) ? Base + 32'(4 * c) : 32'h0;
      b_wr = wr_n;
      start_pass(2'b00);
      wait_done("rnd", 600, cyc);
      check("rnd_cnt", ERR_COUNT, exp_err);
      check("rnd_error", ERROR, exp_err != 0);
      check("rnd_nwr", wr_n - b_wr, N);
    end
    slverr_at = -1;
    corrupt_addr = 32'h0;

    // Write-only and read-only passes.
    b_wr = wr_n; b_rd = rd_n;
    start_pass(2'b01);
    wait_done("wo", 600, cyc);
    check("wo_cnt", ERR_COUNT, 0);
    check("wo_nrd", rd_n - b_rd, 0);
    check_writes("wo", b_wr);
    b_wr = wr_n;
    rd_xor = 32'h0000_0100;
    start_pass(2'b10);
    wait_done("ro_bad", 600, cyc);
    check("ro_bad_cnt", ERR_COUNT, N);
    check("ro_bad_nwr", wr_n - b_wr, 0);
    rd_xor = 32'h0;
    start_pass(2'b10);
    wait_done("ro_ok", 600, cyc);
    check("ro_ok_cnt", ERR_COUNT, 0);
    check("ro_ok_error", ERROR, 0);
    rnd_en = 1'b0;
    tick(2);
    check("skew_viol", viol, 0);

    // 4: reset while write 2 is presenting AWVALID, then a clean pass.
    b_wr = wr_n;
    start_pass(2'b00);
    cyc = 0;
    while (!((wr_n - b_wr) == 2 && axi.M_AXI_AWVALID) && cyc < 50) begin
      tick(1);
      cyc++;
    end
    check("t4_reached_w2", (wr_n - b_wr) == 2 && axi.M_AXI_AWVALID, 1);
    ARESET = 1'b1;
    tick(1);
    check("t4_valids", {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_ARVALID}, 0);
    check("t4_readies", {axi.M_AXI_BREADY, axi.M_AXI_RREADY}, 0);
    check("t4_status", {TXN_DONE, ERROR, ERR_COUNT}, 0);
    check("t4_no_xfer", wr_n - b_wr, 2);
    ARESET = 1'b0;
    tick(1);
    b_wr = wr_n;
    start_pass(2'b00);
    wait_done("t4b", 40, cyc);
    check("t4b_cnt", ERR_COUNT, 0);
    check_writes("t4b", b_wr);

    // 5: illegal mode, then INIT held high for 50 cycles.
    b_v = valid_seen;
    start_pass(2'b11);
    wait_done("t5", 2, cyc);
    check("t5_error", ERROR, 1);
    tick(5);
    check("t5_no_valid", valid_seen - b_v, 0);
    b_wr = wr_n; b_f = done_falls;
    MODE = 2'b00;
    INIT_AXI_TXN = 1'b1;
    tick(50);
    INIT_AXI_TXN = 1'b0;
    tick(1);
    check("t5_one_pass_wr", wr_n - b_wr, N);
    check("t5_one_start", done_falls - b_f, 1);
    check("t5_done", TXN_DONE, 1);
    check("t5_cnt", ERR_COUNT, 0);

`ifdef PTGEN_TIMEOUT_EN
    // 6: slave never answers B; watchdog aborts the pass.
    no_b = 1'b1;
    start_pass(2'b01);
    wait_done("t6", 1200, cyc);
    check("t6_error", ERROR, 1);
    check("t6_cnt", ERR_COUNT, 8'hFF);
    check("t6_idle", {axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_BREADY}, 0);
    no_b = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
